// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//
// Time-multiplexed driver for a row of 7-segment digits with a double-buffered
// content register, optional leading-zero suppression and PWM brightness.
//
// A prescaler produces a "tick" every scan_div+1 cycles. Each tick moves the
// scan to the next digit, and wrapping back to digit 0 marks a frame boundary.
// New content is written into a pending buffer through a load/ready handshake.
// It is promoted to the active buffer only at a frame boundary, so a frame
// never shows a mix of old and new content.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous reset, active low
//   scan_div     slot length minus one, in clk cycles
//   bright       brightness duty code (0 = dark, F = full on)
//   load         write request for din / dp_in / blank_in
//   ready        pending buffer free; load is accepted only while high
//   din          hex nibbles, digit i = din[4i+3:4i]
//   dp_in        per-digit decimal point
//   blank_in     per-digit forced blank
//   lz_suppress  leading-zero suppression enable
//   an           anode enables (registered, polarity per AN_ACTIVE_LOW)
//   seg          segments gfedcba (registered, polarity per SEG_ACTIVE_LOW)
//   dp           decimal point (registered, polarity per SEG_ACTIVE_LOW)
//   digit_idx    index of the digit currently being scanned
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int DIGITS         = 8,
    parameter int PRESC_W        = 20,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PRESC_W-1:0]         scan_div,
    input  logic [3:0]                 bright,
    input  logic                       load,
    output logic                       ready,
    input  logic [4*DIGITS-1:0]        din,
    input  logic [DIGITS-1:0]          dp_in,
    input  logic [DIGITS-1:0]          blank_in,
    input  logic                       lz_suppress,
    output logic [DIGITS-1:0]          an,
    output logic [6:0]                 seg,
    output logic                       dp,
    output logic [$clog2(DIGITS)-1:0]  digit_idx
);

    localparam int                IDX_W    = $clog2(DIGITS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_OFF   = AN_ACTIVE_LOW ? '1 : '0;
    localparam logic [6:0]        SEG_OFF  = SEG_ACTIVE_LOW ? '1 : '0;
    localparam logic              DP_OFF   = SEG_ACTIVE_LOW;

    // Hex digit to active-high gfedcba pattern.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            4'hF: return 7'h71;
        endcase
    endfunction

    // Scan timing state
    logic [PRESC_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]    digit_idx_q, digit_idx_d;
    logic [3:0]          pwm_q, pwm_d;

    // Active (displayed) and pending (just loaded) content
    logic [4*DIGITS-1:0] act_din_q, act_din_d;
    logic [DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [DIGITS-1:0]   act_blank_q, act_blank_d;
    logic [4*DIGITS-1:0] pend_din_q, pend_din_d;
    logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [DIGITS-1:0]   pend_blank_q, pend_blank_d;
    logic                pend_valid_q, pend_valid_d;
    logic                ready_q, ready_d;

    // Registered pin drivers
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;

    logic                tick;
    logic                frame_end;
    logic [DIGITS-1:0]   suppress;

    // Leading-zero suppression. zero_run[i] is set when digit i and every
    // digit above it hold nibble 0 and no digit above i lights its dp. The
    // digit's own dp does not stop it from blanking: a suppressed digit still
    // shows its dp, which is how a lone decimal point on a zero top digit is
    // displayed.
    always_comb begin
        logic [DIGITS:0] zero_run;
        logic [DIGITS:0] dp_ext;
        dp_ext           = {1'b0, act_dp_q};
        zero_run         = '0;
        zero_run[DIGITS] = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run[i] = zero_run[i+1] && !dp_ext[i+1] && (act_din_q[4*i +: 4] == 4'h0);
        end
        suppress    = zero_run[DIGITS-1:0];
        suppress[0] = 1'b0;
        if (!lz_suppress) begin
            suppress = '0;
        end
    end

    // Prescaler, scan index, PWM and buffer handshake.
    // NOTE: every variable gets a default at the top of the block so that no
    // path leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        cnt_d        = cnt_q + 1'b1;
        digit_idx_d  = digit_idx_q;
        pwm_d        = pwm_q + 4'd1;
        act_din_d    = act_din_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        pend_din_d   = pend_din_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        pend_valid_d = pend_valid_q;

        // ">=" rather than "==" so that lowering scan_div mid-slot ends the
        // slot on the next cycle instead of waiting for cnt to wrap.
        tick      = (cnt_q >= scan_div);
        frame_end = tick && (digit_idx_q == LAST_IDX);

        if (tick) begin
            cnt_d       = '0;
            digit_idx_d = frame_end ? '0 : digit_idx_q + 1'b1;
        end

        if (frame_end && pend_valid_q) begin
            act_din_d    = pend_din_q;
            act_dp_d     = pend_dp_q;
            act_blank_d  = pend_blank_q;
            pend_valid_d = 1'b0;
        end

        // Never overlaps the promotion above: ready_q is low whenever
        // pend_valid_q is high. A load landing on a boundary therefore waits
        // for the following boundary.
        if (load && ready_q) begin
            pend_din_d   = din;
            pend_dp_d    = dp_in;
            pend_blank_d = blank_in;
            pend_valid_d = 1'b1;
        end

        ready_d = !pend_valid_d;
    end

    // Pin drivers, computed from the current scan position and active buffer.
    always_comb begin
        logic [3:0]        cur_nib;
        logic              cur_blank;
        logic [6:0]        seg_on;
        logic [DIGITS-1:0] an_on;

        cur_nib   = act_din_q[{digit_idx_q, 2'b00} +: 4];
        cur_blank = act_blank_q[digit_idx_q] || suppress[digit_idx_q];
        seg_on    = cur_blank ? 7'h00 : hex_to_seg(cur_nib);

        an_on = '0;
        if (bright == 4'hF || pwm_q < bright) begin
            an_on[digit_idx_q] = 1'b1;
        end

        an_d  = AN_ACTIVE_LOW  ? ~an_on  : an_on;
        seg_d = SEG_ACTIVE_LOW ? ~seg_on : seg_on;
        dp_d  = SEG_ACTIVE_LOW ? !act_dp_q[digit_idx_q] : act_dp_q[digit_idx_q];
    end

    // NOTE: non-blocking assignments here so every flop samples the values
    // from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q        <= '0;
            digit_idx_q  <= '0;
            pwm_q        <= '0;
            // NOTE: the content buffers are a handful of flops, not a RAM, so
            // they are reset; this is what guarantees reset discards pending
            // data. The active blank mask resets to all ones so a freshly
            // reset display stays dark until the first load is promoted.
            act_din_q    <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '1;
            pend_din_q   <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
        end else begin
            cnt_q        <= cnt_d;
            digit_idx_q  <= digit_idx_d;
            pwm_q        <= pwm_d;
            act_din_q    <= act_din_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            pend_din_q   <= pend_din_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            pend_valid_q <= pend_valid_d;
            ready_q      <= ready_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign ready     = ready_q;
    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign digit_idx = digit_idx_q;

endmodule
